// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle from the timing generator to the pixel pipeline.
interface vga_timing_gen_if #(
    parameter int COORD_W = 10,
    parameter int FRAME_W = 8
);
    logic [COORD_W-1:0] x_o;
    logic [COORD_W-1:0] y_o;
    logic               hsync_o;
    logic               vsync_o;
    logic               de_o;
    logic               line_start_o;
    logic               frame_start_o;
    logic [FRAME_W-1:0] frame_cnt_o;
    logic               busy_o;

    modport master (
        output x_o, y_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o,
               frame_cnt_o, busy_o
    );
    modport slave (
        input  x_o, y_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o,
               frame_cnt_o, busy_o
    );
endinterface

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register; reset loads RST_VAL into every stage so a
// flush leaves the output at the idle levels immediately.
module vga_delay_line #(
    parameter int               WIDTH   = 5,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= {DEPTH{RST_VAL}};
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: coordinates lead the sync/DE strobes
// by LEAD cycles so a pipelined pixel generator's RGB lines up with de_o.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2,
    parameter int COORD_W  = 10,
    parameter int FRAME_W  = 8
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              run_i,
    vga_timing_gen_if.master  vid
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG   = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG   = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    // Strobe order {hs, vs, de, ls, fs}; idle means sync lines at their inactive level.
    localparam logic [4:0] STRB_IDLE = {~HS_POL, ~VS_POL, 3'b000};

    if (COORD_W < $clog2(max2(H_TOTAL, V_TOTAL))) begin : g_chk_coord_w
        $error("COORD_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (LEAD < 0 || LEAD > 7) begin : g_chk_lead
        $error("LEAD must be in 0..7");
    end

    vga_state_t         state_q, state_d;
    logic               cnt_en;
    logic               last_px;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic               hs_act, vs_act, de_act, ls_act, fs_act;
    logic [4:0]         strb, strb_q;

    assign last_px = (h_q == H_LAST) && (v_q == V_LAST);

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // DRAIN keeps counting; run_i wins over the frame-end exit so re-arming never gaps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run_i) state_d = RUN;
            RUN:     if (!run_i) state_d = DRAIN;
            DRAIN: begin
                if (run_i)        state_d = RUN;
                else if (last_px) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_en = (state_q == RUN) || (state_q == DRAIN);
    end

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        fcnt_d = fcnt_q;
        if (cnt_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            if (last_px) fcnt_d = fcnt_q + 1'b1;
        end else begin
            h_d = '0;
            v_d = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            h_q    <= '0;
            v_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            fcnt_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            x_q    <= h_q;
            y_q    <= v_q;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        hs_act = cnt_en && (int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END);
        vs_act = cnt_en && (int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END);
        de_act = cnt_en && (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        ls_act = cnt_en && (h_q == '0) && (int'(v_q) < V_ACTIVE);
        fs_act = cnt_en && (h_q == '0) && (v_q == '0);
        strb   = {hs_act ? HS_POL : ~HS_POL,
                  vs_act ? VS_POL : ~VS_POL,
                  de_act, ls_act, fs_act};
    end

    // First stage sits alongside x_q/y_q; the remaining LEAD stages provide the lead.
    vga_delay_line #(
        .WIDTH   (5),
        .DEPTH   (LEAD + 1),
        .RST_VAL (STRB_IDLE)
    ) u_dly (
        .clk   (pixel_clk),
        .rst_n (reset_n),
        .d_i   (strb),
        .q_o   (strb_q)
    );

    assign vid.x_o           = x_q;
    assign vid.y_o           = y_q;
    assign vid.hsync_o       = strb_q[4];
    assign vid.vsync_o       = strb_q[3];
    assign vid.de_o          = strb_q[2];
    assign vid.line_start_o  = strb_q[1];
    assign vid.frame_start_o = strb_q[0];
    assign vid.frame_cnt_o   = fcnt_q;
    assign vid.busy_o        = cnt_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance (A) and a small 14x7 instance (B, LEAD=3, HS_POL=1).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a_n, run_a, rst_b_n, run_b;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COORD_W(10), .FRAME_W(8)) vid_a ();
    vga_timing_gen_if #(.COORD_W(4),  .FRAME_W(3)) vid_b ();

    vga_timing_gen u_a (
        .pixel_clk (clk),
        .reset_n   (rst_a_n),
        .run_i     (run_a),
        .vid       (vid_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b0), .LEAD (3),
        .COORD_W  (4), .FRAME_W (3)
    ) u_b (
        .pixel_clk (clk),
        .reset_n   (rst_b_n),
        .run_i     (run_b),
        .vid       (vid_b)
    );

    task automatic wait_xy_a(input int x, input int y, input int budget, input string tag);
        int n;
        n = 0;
        while (!(int'(vid_a.x_o) == x && int'(vid_a.y_o) == y) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout waiting for x_o=%0d y_o=%0d", tag, x, y);
        end
    endtask

    task automatic wait_xy_b(input int x, input int y, input int budget, input string tag);
        int n;
        n = 0;
        while (!(int'(vid_b.x_o) == x && int'(vid_b.y_o) == y) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout waiting for x_o=%0d y_o=%0d", tag, x, y);
        end
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0; run_a = 1'b1; run_b = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (vid_a.hsync_o !== 1'b1) begin n_err++; $display("FAIL rst_hsync_a: got %b want 1", vid_a.hsync_o); end
        n_cmp++; if (vid_a.vsync_o !== 1'b1) begin n_err++; $display("FAIL rst_vsync_a: got %b want 1", vid_a.vsync_o); end
        n_cmp++; if (vid_a.de_o !== 1'b0) begin n_err++; $display("FAIL rst_de_a: got %b want 0", vid_a.de_o); end
        n_cmp++; if (vid_a.frame_cnt_o !== 8'd0) begin n_err++; $display("FAIL rst_fcnt_a: got %0d want 0", vid_a.frame_cnt_o); end
        n_cmp++; if (vid_a.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy_a: got %b want 0", vid_a.busy_o); end
        n_cmp++; if (vid_a.x_o !== 10'd0 || vid_a.y_o !== 10'd0) begin n_err++; $display("FAIL rst_xy_a: got (%0d,%0d) want (0,0)", vid_a.x_o, vid_a.y_o); end
        n_cmp++; if (vid_b.hsync_o !== 1'b0) begin n_err++; $display("FAIL rst_hsync_b: got %b want 0", vid_b.hsync_o); end
        n_cmp++; if (vid_b.vsync_o !== 1'b1) begin n_err++; $display("FAIL rst_vsync_b: got %b want 1", vid_b.vsync_o); end
    endtask

    task automatic test_hsync_default();
        int n, per;
        rst_a_n = 1'b1;
        wait_xy_a(656, 0, 2000, "hs_wait656");
        n_cmp++; if (vid_a.hsync_o !== 1'b1) begin n_err++; $display("FAIL hs_at_656: got %b want 1", vid_a.hsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_a.hsync_o !== 1'b1) begin n_err++; $display("FAIL hs_at_657: got %b want 1", vid_a.hsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_a.hsync_o !== 1'b0) begin n_err++; $display("FAIL hs_at_658: got %b want 0", vid_a.hsync_o); end
        n = 0;
        while (vid_a.hsync_o === 1'b0 && n < 2000) begin n++; @(negedge clk); end
        n_cmp++; if (n != 96) begin n_err++; $display("FAIL hs_width: got %0d want 96", n); end
        per = n;
        while (vid_a.hsync_o === 1'b1 && per < 2000) begin per++; @(negedge clk); end
        n_cmp++; if (per != 800) begin n_err++; $display("FAIL hs_period: got %0d want 800", per); end
        wait_xy_a(641, 2, 2000, "de_wait641");
        n_cmp++; if (vid_a.de_o !== 1'b1) begin n_err++; $display("FAIL de_at_641: got %b want 1", vid_a.de_o); end
        @(negedge clk);
        n_cmp++; if (vid_a.de_o !== 1'b0) begin n_err++; $display("FAIL de_at_642: got %b want 0", vid_a.de_o); end
        wait_xy_a(1, 3, 2000, "ls_wait");
        n_cmp++; if (vid_a.line_start_o !== 1'b0) begin n_err++; $display("FAIL ls_at_1: got %b want 0", vid_a.line_start_o); end
        @(negedge clk);
        n_cmp++; if (vid_a.line_start_o !== 1'b1) begin n_err++; $display("FAIL ls_at_2: got %b want 1", vid_a.line_start_o); end
        n_cmp++; if (vid_a.frame_start_o !== 1'b0) begin n_err++; $display("FAIL fs_line3: got %b want 0", vid_a.frame_start_o); end
        n_cmp++; if (vid_a.vsync_o !== 1'b1) begin n_err++; $display("FAIL vs_line3: got %b want 1", vid_a.vsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_a.line_start_o !== 1'b0) begin n_err++; $display("FAIL ls_at_3: got %b want 0", vid_a.line_start_o); end
    endtask

    task automatic test_frame_small();
        int n, per, vlow;
        rst_b_n = 1'b1;
        n = 0;
        while (vid_b.frame_start_o !== 1'b1 && n < 300) begin n++; @(negedge clk); end
        n_cmp++; if (n >= 300) begin n_err++; $display("FAIL fs_first: timeout, frame_start_o never seen"); end
        n_cmp++; if (vid_b.x_o !== 4'd3 || vid_b.y_o !== 4'd0) begin n_err++; $display("FAIL fs_pos: got (%0d,%0d) want (3,0)", vid_b.x_o, vid_b.y_o); end
        n_cmp++; if (vid_b.frame_cnt_o !== 3'd0) begin n_err++; $display("FAIL fcnt_0: got %0d want 0", vid_b.frame_cnt_o); end
        @(negedge clk);
        per = 1; vlow = 0;
        while (vid_b.frame_start_o !== 1'b1 && per < 300) begin
            if (vid_b.vsync_o === 1'b0) vlow++;
            @(negedge clk);
            per++;
        end
        n_cmp++; if (per != 98) begin n_err++; $display("FAIL frame_period: got %0d want 98", per); end
        n_cmp++; if (vlow != 14) begin n_err++; $display("FAIL vs_width: got %0d want 14", vlow); end
        n_cmp++; if (vid_b.frame_cnt_o !== 3'd1) begin n_err++; $display("FAIL fcnt_1: got %0d want 1", vid_b.frame_cnt_o); end
        wait_xy_b(2, 5, 300, "vs_wait");
        n_cmp++; if (vid_b.vsync_o !== 1'b1) begin n_err++; $display("FAIL vs_before: got %b want 1", vid_b.vsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.vsync_o !== 1'b0) begin n_err++; $display("FAIL vs_start: got %b want 0", vid_b.vsync_o); end
        wait_xy_b(3, 0, 300, "fs2_wait");
        n_cmp++; if (vid_b.frame_start_o !== 1'b1) begin n_err++; $display("FAIL fs_2: got %b want 1", vid_b.frame_start_o); end
        n_cmp++; if (vid_b.frame_cnt_o !== 3'd2) begin n_err++; $display("FAIL fcnt_2: got %0d want 2", vid_b.frame_cnt_o); end
        n = 0;
        while (vid_b.frame_cnt_o !== 3'd7 && n < 1000) begin n++; @(negedge clk); end
        n_cmp++; if (n >= 1000) begin n_err++; $display("FAIL fcnt_7: timeout, got %0d", vid_b.frame_cnt_o); end
        n = 0;
        while (vid_b.frame_cnt_o === 3'd7 && n < 300) begin n++; @(negedge clk); end
        n_cmp++; if (n != 98 || vid_b.frame_cnt_o !== 3'd0) begin n_err++; $display("FAIL fcnt_wrap: got %0d after %0d cycles want 0 after 98", vid_b.frame_cnt_o, n); end
    endtask

    task automatic test_small_strobes();
        wait_xy_b(2, 1, 300, "de_b_wait");
        n_cmp++; if (vid_b.de_o !== 1'b0) begin n_err++; $display("FAIL de_b_pre: got %b want 0", vid_b.de_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.de_o !== 1'b1) begin n_err++; $display("FAIL de_b_rise: got %b want 1", vid_b.de_o); end
        wait_xy_b(10, 1, 300, "de_b_end");
        n_cmp++; if (vid_b.de_o !== 1'b1) begin n_err++; $display("FAIL de_b_last: got %b want 1", vid_b.de_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.de_o !== 1'b0) begin n_err++; $display("FAIL de_b_fall: got %b want 0", vid_b.de_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.hsync_o !== 1'b0) begin n_err++; $display("FAIL hs_b_pre: got %b want 0", vid_b.hsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.hsync_o !== 1'b1) begin n_err++; $display("FAIL hs_b_on1: got %b want 1", vid_b.hsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.hsync_o !== 1'b1) begin n_err++; $display("FAIL hs_b_on2: got %b want 1", vid_b.hsync_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.hsync_o !== 1'b0) begin n_err++; $display("FAIL hs_b_off: got %b want 0", vid_b.hsync_o); end
        wait_xy_b(5, 4, 300, "de_b_blank");
        n_cmp++; if (vid_b.de_o !== 1'b0) begin n_err++; $display("FAIL de_b_vblank: got %b want 0", vid_b.de_o); end
    endtask

    task automatic test_run_stop();
        int n, idle;
        logic [2:0] cnt_exp;
        wait_xy_b(0, 2, 300, "stop_wait");
        run_b = 1'b0;
        cnt_exp = vid_b.frame_cnt_o + 3'd1;
        n = 0;
        while (vid_b.busy_o === 1'b1 && n < 300) begin n++; @(negedge clk); end
        n_cmp++; if (vid_b.x_o !== 4'd13 || vid_b.y_o !== 4'd6) begin n_err++; $display("FAIL stop_pos: got (%0d,%0d) want (13,6)", vid_b.x_o, vid_b.y_o); end
        n_cmp++; if (vid_b.frame_cnt_o !== cnt_exp) begin n_err++; $display("FAIL stop_fcnt: got %0d want %0d", vid_b.frame_cnt_o, cnt_exp); end
        repeat (5) @(negedge clk);
        n_cmp++; if (vid_b.busy_o !== 1'b0 || vid_b.x_o !== 4'd0 || vid_b.y_o !== 4'd0) begin n_err++; $display("FAIL idle_state: got busy=%b (%0d,%0d) want busy=0 (0,0)", vid_b.busy_o, vid_b.x_o, vid_b.y_o); end
        n_cmp++; if (vid_b.de_o !== 1'b0 || vid_b.hsync_o !== 1'b0 || vid_b.vsync_o !== 1'b1) begin n_err++; $display("FAIL idle_strobes: got de=%b hs=%b vs=%b want 0 0 1", vid_b.de_o, vid_b.hsync_o, vid_b.vsync_o); end
        run_b = 1'b1;
        wait_xy_b(11, 6, 300, "drain_wait");
        run_b = 1'b0;
        @(negedge clk);
        run_b = 1'b1;
        n = 0;
        while (vid_b.frame_start_o !== 1'b1 && n < 300) begin n++; @(negedge clk); end
        n_cmp++; if (n != 5) begin n_err++; $display("FAIL rearm_fs: got %0d cycles want 5", n); end
        idle = 0;
        for (int i = 0; i < 150; i++) begin
            if (vid_b.busy_o !== 1'b1) idle++;
            @(negedge clk);
        end
        n_cmp++; if (idle != 0) begin n_err++; $display("FAIL rearm_gap: got %0d idle cycles want 0", idle); end
    endtask

    task automatic test_reset_midframe();
        wait_xy_b(5, 2, 300, "rst_wait");
        rst_b_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (vid_b.x_o !== 4'd0 || vid_b.y_o !== 4'd0) begin n_err++; $display("FAIL mrst_xy: got (%0d,%0d) want (0,0)", vid_b.x_o, vid_b.y_o); end
        n_cmp++; if (vid_b.hsync_o !== 1'b0 || vid_b.vsync_o !== 1'b1) begin n_err++; $display("FAIL mrst_sync: got hs=%b vs=%b want 0 1", vid_b.hsync_o, vid_b.vsync_o); end
        n_cmp++; if (vid_b.de_o !== 1'b0 || vid_b.line_start_o !== 1'b0 || vid_b.frame_start_o !== 1'b0) begin n_err++; $display("FAIL mrst_strb: got de=%b ls=%b fs=%b want 0 0 0", vid_b.de_o, vid_b.line_start_o, vid_b.frame_start_o); end
        n_cmp++; if (vid_b.frame_cnt_o !== 3'd0 || vid_b.busy_o !== 1'b0) begin n_err++; $display("FAIL mrst_cnt: got fcnt=%0d busy=%b want 0 0", vid_b.frame_cnt_o, vid_b.busy_o); end
        rst_b_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (vid_b.busy_o !== 1'b1 || vid_b.x_o !== 4'd0) begin n_err++; $display("FAIL restart_busy: got busy=%b x=%0d want 1 0", vid_b.busy_o, vid_b.x_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.x_o !== 4'd0 || vid_b.y_o !== 4'd0) begin n_err++; $display("FAIL restart_xy0: got (%0d,%0d) want (0,0)", vid_b.x_o, vid_b.y_o); end
        @(negedge clk);
        n_cmp++; if (vid_b.x_o !== 4'd1 || vid_b.y_o !== 4'd0) begin n_err++; $display("FAIL restart_xy1: got (%0d,%0d) want (1,0)", vid_b.x_o, vid_b.y_o); end
        repeat (2) @(negedge clk);
        n_cmp++; if (vid_b.x_o !== 4'd3 || vid_b.frame_start_o !== 1'b1) begin n_err++; $display("FAIL restart_fs: got x=%0d fs=%b want 3 1", vid_b.x_o, vid_b.frame_start_o); end
    endtask

    initial begin
        test_reset();
        test_hsync_default();
        test_frame_small();
        test_small_strobes();
        test_run_stop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
